// File: rtl/axi_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_rd_if -- AXI read-only channel bundle (AR + R) used by axi_rd_arbiter.
//
// One instance carries one AR/R channel pair.
//
// Parameters
//   ADDR_W : width of araddr
//   DATA_W : width of rdata
//
// Modports
//   master : the side that issues AR requests and consumes R beats
//            (drives ar*, rready; observes arready, r*)
//   slave  : the side that accepts AR requests and produces R beats
//            (drives arready, r*; observes ar*, rready)
// ---------------------------------------------------------------------------
interface axi_rd_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic [1:0]        arburst;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic              arready;

    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rlast;
    logic              rready;

    modport master (
        output araddr, arvalid, arburst, arlen, arsize, rready,
        input  arready, rdata, rresp, rvalid, rlast
    );

    modport slave (
        input  araddr, arvalid, arburst, arlen, arsize, rready,
        output arready, rdata, rresp, rvalid, rlast
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter -- two-master to one-slave AXI read arbiter.
//
// Master 0 is the fetch cache, master 1 is the data cache. Exactly one read
// transaction is in flight at a time: a winner is latched in IDLE, its AR is
// forwarded in ADDR, and its R beats are forwarded in DATA until the slave
// signals rlast. The burst end is taken purely from rlast (no beat counting),
// and an error rresp does not terminate the burst.
//
// Ports
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   m0    : axi_rd_if.slave  -- fetch-cache master channel
//   m1    : axi_rd_if.slave  -- data-cache master channel
//   s     : axi_rd_if.master -- memory slave channel
//   busy  : high in any state other than IDLE
//   owner : index of the current or last granted master
//
// Configuration
//   AXI_RD_ARB_FIXED_PRIO_EN : when defined, master 1 always wins a
//   simultaneous request (no round-robin). Ports and latency are unchanged.
//
// State table
//   state | meaning
//   IDLE  | no transaction; arbitrate pending arvalids, latch winner
//   ADDR  | owner's AR forwarded to slave, waiting for s.arready
//   DATA  | owner's R beats forwarded, waiting for rvalid & rready & rlast
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic     clk,
    input  logic     rst,
    axi_rd_if.slave  m0,
    axi_rd_if.slave  m1,
    axi_rd_if.master s,
    output logic     busy,
    output logic     owner
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;

    logic              req0, req1;
    logic              winner;
    logic [ADDR_W-1:0] sel_araddr;
    logic              sel_arvalid;
    logic [1:0]        sel_arburst;
    logic [7:0]        sel_arlen;
    logic [2:0]        sel_arsize;
    logic              sel_rready;
    logic [DATA_W-1:0] rdata_bc;

    // ------------------------------------------------------------------
    // State and owner registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign req0 = m0.arvalid;
    assign req1 = m1.arvalid;

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    // Data cache always wins; fetch cache only gets the bus when m1 is quiet.
    assign winner = req1;
`else
    // owner_q doubles as the round-robin pointer: it holds the last granted
    // master, and a tie goes to the other one. Reset leaves it at 0, so
    // master 1 wins the first tie.
    always_comb begin
        winner = req1;
        if (req0 && req1) begin
            winner = ~owner_q;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Owner-side channel selection
    // ------------------------------------------------------------------
    always_comb begin
        if (owner_q) begin
            sel_araddr  = m1.araddr;
            sel_arvalid = m1.arvalid;
            sel_arburst = m1.arburst;
            sel_arlen   = m1.arlen;
            sel_arsize  = m1.arsize;
            sel_rready  = m1.rready;
        end else begin
            sel_araddr  = m0.araddr;
            sel_arvalid = m0.arvalid;
            sel_arburst = m0.arburst;
            sel_arlen   = m0.arlen;
            sel_arsize  = m0.arsize;
            sel_rready  = m0.rready;
        end
    end

    // Data/resp/last go to both masters; only rvalid is steered.
    assign rdata_bc = s.rdata;
    assign m0.rdata = rdata_bc;
    assign m1.rdata = rdata_bc;
    assign m0.rresp = s.rresp;
    assign m1.rresp = s.rresp;
    assign m0.rlast = s.rlast;
    assign m1.rlast = s.rlast;

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;

        s.araddr   = '0;
        s.arvalid  = 1'b0;
        s.arburst  = 2'b00;
        s.arlen    = 8'd0;
        s.arsize   = 3'd0;
        s.rready   = 1'b0;
        m0.arready = 1'b0;
        m1.arready = 1'b0;
        m0.rvalid  = 1'b0;
        m1.rvalid  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    owner_d = winner;
                    state_d = ST_ADDR;
                end
            end

            ST_ADDR: begin
                s.araddr  = sel_araddr;
                s.arvalid = sel_arvalid;
                s.arburst = sel_arburst;
                s.arlen   = sel_arlen;
                s.arsize  = sel_arsize;
                if (owner_q) begin
                    m1.arready = s.arready;
                end else begin
                    m0.arready = s.arready;
                end
                if (sel_arvalid && s.arready) begin
                    state_d = ST_DATA;
                end else if (!sel_arvalid) begin
                    // Owner withdrew its request before acceptance.
                    state_d = ST_IDLE;
                end
            end

            ST_DATA: begin
                s.rready = sel_rready;
                if (owner_q) begin
                    m1.rvalid = s.rvalid;
                end else begin
                    m0.rvalid = s.rvalid;
                end
                // rresp is ignored here: an error beat does not end the burst.
                if (s.rvalid && sel_rready && s.rlast) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset silences every handshake in the very cycle it is sampled,
        // so an abandoned burst never leaks a beat or an accept.
        if (rst) begin
            s.arvalid  = 1'b0;
            s.rready   = 1'b0;
            m0.arready = 1'b0;
            m1.arready = 1'b0;
            m0.rvalid  = 1'b0;
            m1.rvalid  = 1'b0;
        end
    end

    assign busy  = (state_q != ST_IDLE) && !rst;
    assign owner = rst ? 1'b0 : owner_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter -- directed self-checking bench for axi_rd_arbiter.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    logic clk;
    logic rst;
    logic busy;
    logic owner;

    int n_chk  = 0;
    int n_fail = 0;

    axi_rd_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
    axi_rd_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
    axi_rd_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

    axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if),
        .busy  (busy),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_val("rst_busy",    64'(busy), 64'd0);
        check_val("rst_owner",   64'(owner), 64'd0);
        check_val("rst_s_arv",   64'(s_if.arvalid), 64'd0);
        check_val("rst_s_rrdy",  64'(s_if.rready), 64'd0);
        check_val("rst_rvalid",  64'({m0_if.rvalid, m1_if.rvalid}), 64'd0);
        check_val("rst_arready", 64'({m0_if.arready, m1_if.arready}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Entered at a falling edge with the arbiter in IDLE and requests driven.
    // Leaves at the falling edge where the arbiter has entered DATA.
    task automatic addr_phase(input bit own, input logic [31:0] addr,
                              input logic [7:0] len, input bit drop);
        #1;
        check_val("idle_busy",    64'(busy), 64'd0);
        check_val("idle_s_arv",   64'(s_if.arvalid), 64'd0);
        check_val("idle_arready", 64'({m0_if.arready, m1_if.arready}), 64'd0);
        check_val("idle_rvalid",  64'({m0_if.rvalid, m1_if.rvalid}), 64'd0);
        @(negedge clk);
        #1;
        check_val("addr_busy",   64'(busy), 64'd1);
        check_val("addr_owner",  64'(owner), 64'(own));
        check_val("addr_s_arv",  64'(s_if.arvalid), 64'd1);
        check_val("addr_araddr", 64'(s_if.araddr), 64'(addr));
        check_val("addr_arlen",  64'(s_if.arlen), 64'(len));
        check_val("addr_arrdy_own",   64'(own ? m1_if.arready : m0_if.arready), 64'd1);
        check_val("addr_arrdy_other", 64'(own ? m0_if.arready : m1_if.arready), 64'd0);
        @(negedge clk);
        if (drop) begin
            if (own) m1_if.arvalid = 1'b0;
            else     m0_if.arvalid = 1'b0;
        end
    endtask

    // n back-to-back beats from the slave; optional SLVERR on beat 0.
    task automatic beats(input bit own, input int n, input bit err0);
        for (int i = 0; i < n; i++) begin
            s_if.rvalid  = 1'b1;
            s_if.rdata   = 64'hD000_0000_0000_0000 + 64'(i);
            s_if.rresp   = (err0 && i == 0) ? 2'b10 : 2'b00;
            s_if.rlast   = (i == n - 1);
            m0_if.rready = 1'b1;
            m1_if.rready = 1'b1;
            #1;
            check_val("beat_busy",      64'(busy), 64'd1);
            check_val("beat_rv_own",    64'(own ? m1_if.rvalid : m0_if.rvalid), 64'd1);
            check_val("beat_rv_other",  64'(own ? m0_if.rvalid : m1_if.rvalid), 64'd0);
            check_val("beat_s_rready",  64'(s_if.rready), 64'd1);
            check_val("beat_rdata",     own ? m1_if.rdata : m0_if.rdata,
                      64'hD000_0000_0000_0000 + 64'(i));
            check_val("beat_rresp",     64'(own ? m1_if.rresp : m0_if.rresp),
                      (err0 && i == 0) ? 64'd2 : 64'd0);
            @(negedge clk);
        end
        s_if.rvalid = 1'b0;
        s_if.rlast  = 1'b0;
        s_if.rresp  = 2'b00;
        #1;
        check_val("end_busy",   64'(busy), 64'd0);
        check_val("end_rvalid", 64'({m0_if.rvalid, m1_if.rvalid}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pv;
        logic [15:0] pr;
        int          b;
        bit          exp_own;

        rst = 1'b1;
        m0_if.araddr = '0; m0_if.arvalid = 1'b0; m0_if.arburst = 2'b01;
        m0_if.arlen = 8'd0; m0_if.arsize = 3'd3; m0_if.rready = 1'b0;
        m1_if.araddr = '0; m1_if.arvalid = 1'b0; m1_if.arburst = 2'b01;
        m1_if.arlen = 8'd0; m1_if.arsize = 3'd3; m1_if.rready = 1'b0;
        s_if.arready = 1'b1; s_if.rdata = '0; s_if.rresp = 2'b00;
        s_if.rvalid = 1'b0; s_if.rlast = 1'b0;

        do_reset();

        // Single m0 read, one beat
        m0_if.araddr  = 32'h8000_0000;
        m0_if.arlen   = 8'd0;
        m0_if.arvalid = 1'b1;
        addr_phase(1'b0, 32'h8000_0000, 8'd0, 1'b1);
        s_if.rvalid   = 1'b1;
        s_if.rdata    = 64'h0000_0013_0000_0093;
        s_if.rlast    = 1'b1;
        m0_if.rready  = 1'b1;
        #1;
        check_val("single_m0_rvalid", 64'(m0_if.rvalid), 64'd1);
        check_val("single_m0_rdata",  m0_if.rdata, 64'h0000_0013_0000_0093);
        check_val("single_m1_rvalid", 64'(m1_if.rvalid), 64'd0);
        check_val("single_busy",      64'(busy), 64'd1);
        @(negedge clk);
        s_if.rvalid = 1'b0;
        s_if.rlast  = 1'b0;
        #1;
        check_val("single_busy_fall", 64'(busy), 64'd0);
        check_val("single_m0_rv_end", 64'(m0_if.rvalid), 64'd0);
        check_val("single_owner_end", 64'(owner), 64'd0);

        // m1 4-beat burst with slave gaps and rready toggling
        m1_if.araddr  = 32'h3000_0000;
        m1_if.arlen   = 8'd3;
        m1_if.arvalid = 1'b1;
        addr_phase(1'b1, 32'h3000_0000, 8'd3, 1'b1);
        pv = 16'b1111_1111_1110_1101;
        pr = 16'b1111_1111_1101_1011;
        b  = 0;
        for (int c = 0; c < 16 && b < 4; c++) begin
            s_if.rvalid  = pv[c];
            s_if.rdata   = 64'h0000_0000_0000_00B0 + 64'(b);
            s_if.rlast   = (b == 3);
            m1_if.rready = pr[c];
            m0_if.rready = ~pr[c];
            #1;
            check_val("gap_busy",     64'(busy), 64'd1);
            check_val("gap_s_rready", 64'(s_if.rready), 64'(pr[c]));
            check_val("gap_m1_rvalid", 64'(m1_if.rvalid), 64'(pv[c]));
            check_val("gap_m0_rvalid", 64'(m0_if.rvalid), 64'd0);
            if (pv[c] && pr[c]) begin
                check_val("gap_rdata", m1_if.rdata, 64'h0000_0000_0000_00B0 + 64'(b));
                b++;
            end
            @(negedge clk);
        end
        s_if.rvalid = 1'b0;
        s_if.rlast  = 1'b0;
        #1;
        check_val("gap_busy_end", 64'(busy), 64'd0);

        // Error response on beat 0 of 2 does not end the burst
        m0_if.araddr  = 32'h6000_0000;
        m0_if.arlen   = 8'd1;
        m0_if.arvalid = 1'b1;
        addr_phase(1'b0, 32'h6000_0000, 8'd1, 1'b1);
        beats(1'b0, 2, 1'b1);

        // Owner withdraws arvalid while the slave stalls AR
        s_if.arready  = 1'b0;
        m0_if.araddr  = 32'h7000_0000;
        m0_if.arlen   = 8'd0;
        m0_if.arvalid = 1'b1;
        @(negedge clk);
        #1;
        check_val("wd_addr_busy", 64'(busy), 64'd1);
        check_val("wd_s_arvalid", 64'(s_if.arvalid), 64'd1);
        check_val("wd_m0_arready", 64'(m0_if.arready), 64'd0);
        @(negedge clk);
        #1;
        check_val("wd_hold_busy", 64'(busy), 64'd1);
        m0_if.arvalid = 1'b0;
        #1;
        check_val("wd_s_arv_drop", 64'(s_if.arvalid), 64'd0);
        @(negedge clk);
        #1;
        check_val("wd_idle_busy", 64'(busy), 64'd0);
        s_if.arready = 1'b1;

        // Reset on beat 1 of a 4-beat m0 burst, then a clean m1 read
        m0_if.araddr  = 32'h4000_0000;
        m0_if.arlen   = 8'd3;
        m0_if.arvalid = 1'b1;
        addr_phase(1'b0, 32'h4000_0000, 8'd3, 1'b1);
        s_if.rvalid  = 1'b1;
        s_if.rdata   = 64'h1;
        s_if.rlast   = 1'b0;
        m0_if.rready = 1'b1;
        #1;
        check_val("rstb_beat0_rv", 64'(m0_if.rvalid), 64'd1);
        @(negedge clk);
        s_if.rdata = 64'h2;
        rst        = 1'b1;
        #1;
        check_val("rstb_busy",    64'(busy), 64'd0);
        check_val("rstb_rvalid",  64'({m0_if.rvalid, m1_if.rvalid}), 64'd0);
        check_val("rstb_s_rrdy",  64'(s_if.rready), 64'd0);
        check_val("rstb_owner",   64'(owner), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rstb_post_busy",   64'(busy), 64'd0);
        check_val("rstb_post_rvalid", 64'({m0_if.rvalid, m1_if.rvalid}), 64'd0);
        check_val("rstb_post_s_rrdy", 64'(s_if.rready), 64'd0);
        @(negedge clk);
        #1;
        check_val("rstb_late_rvalid", 64'({m0_if.rvalid, m1_if.rvalid}), 64'd0);
        s_if.rvalid   = 1'b0;
        m1_if.araddr  = 32'h5000_0000;
        m1_if.arlen   = 8'd1;
        m1_if.arvalid = 1'b1;
        addr_phase(1'b1, 32'h5000_0000, 8'd1, 1'b1);
        beats(1'b1, 2, 1'b0);

        // Simultaneous requests after reset, four back-to-back pairs
        @(negedge clk);
        do_reset();
        m0_if.araddr  = 32'h1000_0000;
        m0_if.arlen   = 8'd0;
        m1_if.araddr  = 32'h2000_0000;
        m1_if.arlen   = 8'd0;
        m0_if.arvalid = 1'b1;
        m1_if.arvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
            exp_own = 1'b1;
`else
            exp_own = (i % 2 == 0);
`endif
            addr_phase(exp_own, exp_own ? 32'h2000_0000 : 32'h1000_0000, 8'd0, 1'b0);
            beats(exp_own, 1, 1'b0);
        end
        m1_if.arvalid = 1'b0;
        addr_phase(1'b0, 32'h1000_0000, 8'd0, 1'b1);
        beats(1'b0, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
